// File: rtl/hd_program_loader.sv
// Streams a block of consecutive words from the hard-disk store into instruction memory.
// Disk reads are pipelined: one address per cycle, and data comes back READ_LAT cycles later.
module hd_program_loader #(
  parameter int READ_LAT  = 2,
  parameter int IM_AW     = 8,
  parameter int MAX_WORDS = 250
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       src_sector,
  input  logic [9:0]       src_track,
  input  logic [7:0]       num_words,
  input  logic [IM_AW-1:0] dst_addr,
  output logic [3:0]       hd_sector,
  output logic [9:0]       hd_track,
  output logic             hd_we,
  input  logic [31:0]      hd_data,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_data,
  output logic             im_we,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [8:0] MAXW = 9'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state, state_nx;
  logic [7:0]       rem;
  logic [7:0]       off_cnt;
  logic [IM_AW-1:0] dst_q;
  logic             vld_p [READ_LAT];
  logic [7:0]       off_p [READ_LAT];
  logic             pipe_empty, accept, reject, push, fin, kill;

  // Length must be 1..MAX_WORDS and the last track must not pass 1023.
  function automatic logic len_ok(input logic [9:0] trk, input logic [7:0] n);
    logic [10:0] last;
    last = {1'b0, trk} + {3'b000, n} - 11'd1;
    return (n != 8'd0) && ({1'b0, n} <= MAXW) && (last <= 11'd1023);
  endfunction

  function automatic logic [IM_AW-1:0] wrap_addr(input logic [IM_AW-1:0] base,
                                                 input logic [7:0] off);
    return base + IM_AW'(off);
  endfunction

  assign hd_we = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (abort) state_nx = IDLE;
               else if (rem == 8'd1) state_nx = DRAIN;
      DRAIN:   if (abort || pipe_empty) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    pipe_empty = 1'b1;
    for (int i = 0; i < READ_LAT; i++)
      if (vld_p[i]) pipe_empty = 1'b0;
    accept = (state == IDLE) && start && len_ok(src_track, num_words);
    reject = (state == IDLE) && start && !len_ok(src_track, num_words);
    push   = (state == ISSUE) && !abort;
    fin    = (state == DRAIN) && !abort && pipe_empty;
    kill   = busy && abort;
  end

  // p0..p(READ_LAT-1): issue-side valid tracking, aligned with returning disk data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      off_cnt   <= '0;
      hd_sector <= '0;
      hd_track  <= '0;
      im_addr   <= '0;
      im_data   <= '0;
      im_we     <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        error     <= 1'b0;
        hd_sector <= src_sector;
        hd_track  <= src_track;
        rem       <= num_words;
        off_cnt   <= '0;
      end else if (reject) begin
        error <= 1'b1;
      end
      if (push) begin
        rem     <= rem - 8'd1;
        off_cnt <= off_cnt + 8'd1;
        if (rem != 8'd1) hd_track <= hd_track + 10'd1;
      end
      if (kill) begin
        im_we <= 1'b0;
        for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
      end else begin
        vld_p[0] <= push;
        for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
        im_we <= vld_p[READ_LAT-1];
        if (vld_p[READ_LAT-1]) begin
          im_addr <= wrap_addr(dst_q, off_p[READ_LAT-1]);
          im_data <= hd_data;
        end
      end
    end
  end

  // Offsets and destination base are pure data and ride alongside vld_p.
  always_ff @(posedge clock) begin
    if (accept) dst_q <= dst_addr;
    off_p[0] <= off_cnt;
    for (int i = 1; i < READ_LAT; i++) off_p[i] <= off_p[i-1];
  end

endmodule
